// File: rtl/hp_read_arbiter_if.sv
// AXI3 HP read-address and read-data channels (32-bit data, 6-bit ID) used by hp_read_arbiter.
// The master modport is the arbiter side; the slave modport is the PS HP port side.
interface hp_read_arbiter_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [5:0]  arid;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [5:0]  rid;
    logic        rlast;
    logic [1:0]  rresp;

    modport master (
        output arvalid, araddr, arlen, arid, arburst, arsize, arlock, arcache, arprot, arqos,
        input  arready,
        input  rvalid, rdata, rid, rlast, rresp,
        output rready
    );

    modport slave (
        input  arvalid, araddr, arlen, arid, arburst, arsize, arlock, arcache, arprot, arqos,
        output arready,
        output rvalid, rdata, rid, rlast, rresp,
        input  rready
    );
endinterface

// File: rtl/hp_read_arbiter.sv
// Round-robin sharing of one AXI3 HP read port among NUM_REQ requesters, RID-based R routing.
// Optional 4 KB boundary check with a local error beat: define HP_ARB_4K_CHECK_EN.
module hp_read_arbiter #(
    parameter int          NUM_REQ         = 4,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [5:0]  ID_BASE         = 6'h00
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [4*NUM_REQ-1:0] req_len,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic [31:0]          resp_data,
    output logic                 resp_last,
    output logic                 resp_error,
    output logic                 id_error,
    hp_read_arbiter_if.master    axi
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [5:0]       NUM_REQ_ID = 6'(NUM_REQ);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);

`ifdef HP_ARB_4K_CHECK_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_LERR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1} state_t;
`endif

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic              id_error_q, id_error_d;
    logic [31:0]       ar_addr_q, ar_addr_d;
    logic [3:0]        ar_len_q, ar_len_d;
    logic [5:0]        ar_id_q, ar_id_d;
`ifdef HP_ARB_4K_CHECK_EN
    logic [IDX_W-1:0]  lerr_idx_q, lerr_idx_d;
    logic [12:0]       end_off;
    logic              boundary_err;
`endif

    logic [31:0]       addr_arr [NUM_REQ];
    logic [3:0]        len_arr  [NUM_REQ];
    logic              gnt_found;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W:0]    cand;
    logic              grant_ok;
    logic [31:0]       sel_addr;
    logic [3:0]        sel_len;

    logic              arvalid_int;
    logic              ar_hs;
    logic [5:0]        rid_off;
    logic              rid_known;
    logic [IDX_W-1:0]  r_sel;
    logic              route_en;
    logic              rlast_hs;
    logic              cnt_dec;
    logic              underflow;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*32 +: 32];
            len_arr[i]  = req_len[i*4 +: 4];
        end
    end

    // First asserted requester at or after the round-robin pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign sel_addr = {addr_arr[gnt_idx][31:2], 2'b00};
    assign sel_len  = len_arr[gnt_idx];
    assign grant_ok = !reset && (state_q == ST_IDLE) && gnt_found && (outstanding_q < MAX_CNT);

`ifdef HP_ARB_4K_CHECK_EN
    assign end_off      = {1'b0, sel_addr[11:0]} + {6'd0, ({1'b0, sel_len} + 5'd1), 2'b00};
    assign boundary_err = end_off > 13'd4096;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;
        ar_id_d   = ar_id_q;
`ifdef HP_ARB_4K_CHECK_EN
        lerr_idx_d = lerr_idx_q;
`endif
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    req_ready[gnt_idx] = 1'b1;
                    rr_ptr_d  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                    ar_addr_d = sel_addr;
                    ar_len_d  = sel_len;
                    ar_id_d   = ID_BASE | 6'(gnt_idx);
`ifdef HP_ARB_4K_CHECK_EN
                    lerr_idx_d = gnt_idx;
                    state_d    = boundary_err ? ST_LERR : ST_ISSUE;
`else
                    state_d    = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                if (axi.arready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef HP_ARB_4K_CHECK_EN
            ST_LERR: begin
                if (resp_ready[lerr_idx_q]) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign arvalid_int  = (state_q == ST_ISSUE);
    assign ar_hs        = arvalid_int && axi.arready;

    assign axi.arvalid = arvalid_int;
    assign axi.araddr  = ar_addr_q;
    assign axi.arlen   = ar_len_q;
    assign axi.arid    = ar_id_q;
    assign axi.arburst = 2'b01;
    assign axi.arsize  = 3'b010;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0011;
    assign axi.arprot  = 3'b000;
    assign axi.arqos   = 4'b0000;

    // R routing is purely combinational; the local error beat takes over the response bus.
    assign rid_off   = axi.rid - ID_BASE;
    assign rid_known = rid_off < NUM_REQ_ID;
    assign r_sel     = rid_off[IDX_W-1:0];
`ifdef HP_ARB_4K_CHECK_EN
    assign route_en  = !reset && (state_q != ST_LERR);
`else
    assign route_en  = !reset;
`endif

    always_comb begin
        resp_valid = '0;
        resp_data  = axi.rdata;
        resp_last  = axi.rlast;
        resp_error = (axi.rresp != 2'b00);
        axi.rready = 1'b0;
        if (route_en) begin
            if (rid_known) begin
                resp_valid[r_sel] = axi.rvalid;
                axi.rready        = resp_ready[r_sel];
            end else begin
                axi.rready = 1'b1;
            end
        end
`ifdef HP_ARB_4K_CHECK_EN
        if (!reset && state_q == ST_LERR) begin
            resp_valid[lerr_idx_q] = 1'b1;
            resp_last  = 1'b1;
            resp_error = 1'b1;
            resp_data  = '0;
        end
`endif
    end

    assign rlast_hs  = route_en && rid_known && axi.rvalid && axi.rready && axi.rlast;
    assign cnt_dec   = rlast_hs && (outstanding_q != '0);
    assign underflow = rlast_hs && (outstanding_q == '0);

    always_comb begin
        outstanding_d = outstanding_q;
        case ({ar_hs, cnt_dec})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        id_error_d = id_error_q | underflow | (route_en && axi.rvalid && !rid_known);
    end

    assign id_error = id_error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            id_error_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            id_error_q    <= id_error_d;
        end
    end

    // Burst fields are qualified by state, so they need no reset.
    always_ff @(posedge clock) begin
        ar_addr_q <= ar_addr_d;
        ar_len_q  <= ar_len_d;
        ar_id_q   <= ar_id_d;
`ifdef HP_ARB_4K_CHECK_EN
        lerr_idx_q <= lerr_idx_d;
`endif
    end

endmodule

// File: tb/tb_hp_read_arbiter.sv
// Directed bench for hp_read_arbiter: default instance plus a MAX_OUTSTANDING=2 instance.
module tb_hp_read_arbiter;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [127:0] req_addr;
    logic [15:0]  req_len;
    logic [31:0]  resp_data;
    logic         resp_last, resp_error, id_error;

    logic [3:0]   lreq_valid, lreq_ready, lresp_valid, lresp_ready;
    logic [127:0] lreq_addr;
    logic [15:0]  lreq_len;
    logic [31:0]  lresp_data;
    logic         lresp_last, lresp_error, lid_error;

    hp_read_arbiter_if ax ();
    hp_read_arbiter_if axl ();

    hp_read_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(8), .ID_BASE(6'h00)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_error(resp_error), .id_error(id_error),
        .axi(ax)
    );

    hp_read_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(2), .ID_BASE(6'h00)) dut_lim (
        .clock(clock), .reset(reset),
        .req_valid(lreq_valid), .req_ready(lreq_ready), .req_addr(lreq_addr), .req_len(lreq_len),
        .resp_valid(lresp_valid), .resp_ready(lresp_ready), .resp_data(lresp_data),
        .resp_last(lresp_last), .resp_error(lresp_error), .id_error(lid_error),
        .axi(axl)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rvalid;
        logic [5:0]  rid;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        logic [3:0]  rdy;
        logic [3:0]  exp_valid;
        logic        exp_rready;
        logic        exp_err;
    } rvec_t;

    rvec_t vecs [8];
    int hs;

    initial begin
        vecs[0] = '{1'b1, 6'd1, 2'b00, 32'h1111_1111, 4'b1111, 4'b0010, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 6'd2, 2'b00, 32'h2222_2222, 4'b1011, 4'b0100, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 6'd1, 2'b00, 32'h3333_3333, 4'b1011, 4'b0010, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 6'd2, 2'b00, 32'h4444_4444, 4'b1111, 4'b0100, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 6'd3, 2'b10, 32'h5555_5555, 4'b1000, 4'b1000, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 6'd0, 2'b00, 32'h0000_0000, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 6'd0, 2'b11, 32'h6666_6666, 4'b0000, 4'b0001, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 6'd2, 2'b01, 32'h7777_7777, 4'b0100, 4'b0100, 1'b1, 1'b1};

        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0; resp_ready = '0;
        lreq_valid = '0; lreq_addr = '0; lreq_len = '0; lresp_ready = '0;
        ax.arready = 1'b0; ax.rvalid = 1'b1; ax.rdata = '0; ax.rid = '0; ax.rlast = 1'b0; ax.rresp = '0;
        axl.arready = 1'b0; axl.rvalid = 1'b0; axl.rdata = '0; axl.rid = '0; axl.rlast = 1'b0; axl.rresp = '0;

        // Reset state (rvalid held high to show response gating during reset)
        repeat (3) step();
        check("rst_arvalid", 32'(ax.arvalid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_id_error", 32'(id_error), 32'd0);
        ax.rvalid = 1'b0;
        reset = 1'b0;
        step();

        // Single request
        req_valid = 4'b0001; req_addr[31:0] = 32'h1000_0104; req_len[3:0] = 4'd3;
        #1;
        check("single_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        check("single_arvalid", 32'(ax.arvalid), 32'd1);
        check("single_araddr", ax.araddr, 32'h1000_0104);
        check("single_arlen", 32'(ax.arlen), 32'd3);
        check("single_arid", 32'(ax.arid), 32'd0);
        check("const_arburst", 32'(ax.arburst), 32'd1);
        check("const_arsize", 32'(ax.arsize), 32'd2);
        check("const_arcache", 32'(ax.arcache), 32'd3);
        check("const_misc", 32'({ax.arlock, ax.arprot, ax.arqos}), 32'd0);
        step();
        check("hold_arvalid", 32'(ax.arvalid), 32'd1);
        check("hold_araddr", ax.araddr, 32'h1000_0104);
        ax.arready = 1'b1;
        #1;
        step();
        ax.arready = 1'b0;
        #1;
        check("single_ar_done", 32'(ax.arvalid), 32'd0);
        check("single_out1", 32'(dut.outstanding_q), 32'd1);
        for (int b = 0; b < 4; b++) begin
            ax.rvalid = 1'b1; ax.rid = 6'd0; ax.rdata = 32'hD000_0000 + 32'(b);
            ax.rlast = (b == 3); ax.rresp = 2'b00; resp_ready = 4'b0001;
            #1;
            check("beat_resp_valid", 32'(resp_valid), 32'h1);
            check("beat_resp_data", resp_data, 32'hD000_0000 + 32'(b));
            check("beat_resp_last", 32'(resp_last), (b == 3) ? 32'd1 : 32'd0);
            step();
        end
        ax.rvalid = 1'b0; ax.rlast = 1'b0; resp_ready = '0;
        #1;
        check("single_out0", 32'(dut.outstanding_q), 32'd0);

        // Round-robin with all requesters asserted (reset first so the pointer is 0)
        reset = 1'b1; step(); reset = 1'b0; step();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32] = 32'h2000_0003 + 32'(i) * 32'h100;
            req_len[i*4 +: 4] = 4'(i);
        end
        req_valid = 4'b1111; ax.arready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            check("rr_req_ready", 32'(req_ready), 32'(1) << (g % 4));
            step();
            check("rr_arid", 32'(ax.arid), 32'(g % 4));
            check("rr_araddr", ax.araddr, 32'h2000_0000 + 32'(g % 4) * 32'h100);
            check("rr_arlen", 32'(ax.arlen), 32'(g % 4));
            step();
        end
        req_valid = '0; ax.arready = 1'b0;
        #1;
        check("rr_out5", 32'(dut.outstanding_q), 32'd5);
        resp_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            ax.rvalid = 1'b1; ax.rid = 6'(i % 4); ax.rlast = 1'b1;
            #1;
            step();
        end
        ax.rvalid = 1'b0; ax.rlast = 1'b0;
        #1;
        check("rr_drained", 32'(dut.outstanding_q), 32'd0);

        // Routing / backpressure table
        foreach (vecs[v]) begin
            ax.rvalid = vecs[v].rvalid; ax.rid = vecs[v].rid; ax.rresp = vecs[v].rresp;
            ax.rdata = vecs[v].rdata; ax.rlast = 1'b0; resp_ready = vecs[v].rdy;
            #1;
            check("tbl_resp_valid", 32'(resp_valid), 32'(vecs[v].exp_valid));
            check("tbl_rready", 32'(ax.rready), 32'(vecs[v].exp_rready));
            check("tbl_resp_error", 32'(resp_error), 32'(vecs[v].exp_err));
            if (vecs[v].rvalid) check("tbl_resp_data", resp_data, vecs[v].rdata);
            step();
        end
        ax.rvalid = 1'b0; ax.rresp = '0; resp_ready = '0;
        #1;
        check("tbl_no_id_error", 32'(id_error), 32'd0);

        // Unknown RID is drained and flagged
        ax.rvalid = 1'b1; ax.rid = 6'h3F; ax.rlast = 1'b0;
        #1;
        check("unk_rready", 32'(ax.rready), 32'd1);
        check("unk_resp_valid", 32'(resp_valid), 32'd0);
        step();
        ax.rvalid = 1'b0; ax.rid = '0;
        #1;
        check("unk_id_error", 32'(id_error), 32'd1);
        step(); step();
        check("unk_id_error_sticky", 32'(id_error), 32'd1);

        // Reset in the middle of ISSUE
        req_valid = 4'b0010;
        #1;
        step();
        req_valid = '0;
        #1;
        check("mid_issue_arvalid", 32'(ax.arvalid), 32'd1);
        reset = 1'b1;
        step();
        check("rst_issue_arvalid", 32'(ax.arvalid), 32'd0);
        check("rst_issue_id_error", 32'(id_error), 32'd0);
        reset = 1'b0;
        step();

        // Outstanding limit on the MAX_OUTSTANDING=2 instance
        lreq_valid = 4'b0001; lreq_addr[31:0] = 32'h3000_0000; lreq_len[3:0] = 4'd0;
        axl.arready = 1'b1; lresp_ready = 4'b0001;
        hs = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (axl.arvalid && axl.arready) hs++;
            step();
        end
        check("lim_two_issues", 32'(hs), 32'd2);
        check("lim_req_ready_blocked", 32'(lreq_ready), 32'd0);
        check("lim_out2", 32'(dut_lim.outstanding_q), 32'd2);
        axl.rvalid = 1'b1; axl.rid = 6'd0; axl.rlast = 1'b1;
        #1;
        step();
        axl.rvalid = 1'b0; axl.rlast = 1'b0;
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (axl.arvalid && axl.arready) hs++;
            step();
        end
        check("lim_one_more", 32'(hs), 32'd1);
        check("lim_out2_again", 32'(dut_lim.outstanding_q), 32'd2);
        axl.arready = 1'b0;
        axl.rvalid = 1'b1; axl.rlast = 1'b1;
        #1;
        step();
        axl.rvalid = 1'b0; axl.rlast = 1'b0;
        #1;
        check("lim_out1", 32'(dut_lim.outstanding_q), 32'd1);
        step();
        check("lim_issue", 32'(axl.arvalid), 32'd1);
        axl.arready = 1'b1; axl.rvalid = 1'b1; axl.rlast = 1'b1;
        #1;
        step();
        axl.arready = 1'b0; axl.rvalid = 1'b0; axl.rlast = 1'b0; lreq_valid = '0;
        #1;
        check("lim_simul_unchanged", 32'(dut_lim.outstanding_q), 32'd1);

        // 4 KB boundary handling
        req_valid = 4'b0100; req_addr[95:64] = 32'h0000_0FF8; req_len[11:8] = 4'd3;
        #1;
        check("k4_req_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
`ifdef HP_ARB_4K_CHECK_EN
        ax.rvalid = 1'b1; ax.rid = 6'd1; ax.rdata = 32'hABCD_0000; resp_ready = 4'b0000;
        #1;
        check("k4_no_arvalid", 32'(ax.arvalid), 32'd0);
        check("k4_resp_valid", 32'(resp_valid), 32'h4);
        check("k4_resp_flags", 32'({resp_last, resp_error}), 32'h3);
        check("k4_resp_data", resp_data, 32'd0);
        check("k4_rready", 32'(ax.rready), 32'd0);
        step();
        check("k4_hold", 32'(resp_valid), 32'h4);
        resp_ready = 4'b0100;
        #1;
        step();
        ax.rvalid = 1'b0; resp_ready = '0;
        #1;
        check("k4_released", 32'(resp_valid), 32'd0);
        check("k4_out0", 32'(dut.outstanding_q), 32'd0);
        req_valid = 4'b0100; req_addr[95:64] = 32'h0000_0FF0;
        #1;
        step();
        req_valid = '0;
        #1;
        check("k4_ok_arvalid", 32'(ax.arvalid), 32'd1);
        check("k4_ok_araddr", ax.araddr, 32'h0000_0FF0);
`else
        #1;
        check("k4_off_arvalid", 32'(ax.arvalid), 32'd1);
        check("k4_off_araddr", ax.araddr, 32'h0000_0FF8);
`endif
        ax.arready = 1'b1;
        #1;
        step();
        ax.arready = 1'b0;
        ax.rvalid = 1'b1; ax.rid = 6'd2; ax.rlast = 1'b1; resp_ready = 4'b0100;
        #1;
        step();
        ax.rvalid = 1'b0; ax.rlast = 1'b0; resp_ready = '0;
        #1;
        check("k4_final_out0", 32'(dut.outstanding_q), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
